// File: rtl/ecc_mem_seq.sv
// ecc_mem_seq: processor-side sequencer for an ECC-protected asynchronous SRAM pair.
// Runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD -> DONE per accepted request.
// Requests carrying an illegal mode (1xx) go straight to DONE with resp_err set.
// Optional feature macro: ECC_MEM_SEQ_ERRCNT_EN enables the saturating corrected-error
// counter. Without it err_count_o is tied to zero and err_clr_i is ignored.
module ecc_mem_seq #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [15:0]          addr_i,
    input  logic [15:0]          wdata_i,
    input  logic [2:0]           mode_i,
    output logic                 ack_o,
    output logic                 resp_err_o,
    output logic [15:0]          rdata_o,
    output logic                 busy_o,
    output logic [2:0]           ecc_sel_o,
    output logic [15:0]          ecc_wdata_o,
    input  logic [15:0]          ecc_rdata_i,
    input  logic [2:0]           ecc_flag_i,
    output logic [15:0]          mem_addr_o,
    output logic                 mem_cs_o,
    output logic                 mem_we_n_o,
    output logic                 mem_oe_n_o,
    input  logic                 err_clr_i,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StHold,
        StDone
    } state_e;

    localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [2:0]  mode_q;
    logic        resp_q;
    logic [15:0] rdata_q;

    logic accept;
    logic last_access;

    assign accept      = (state_q == StIdle) && req_i;
    assign last_access = (state_q == StAccess) && (cnt_q == 4'd0);

    // State and wait-counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter is loaded on the SETUP -> ACCESS transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    state_d = mode_i[2] ? StDone : StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = CntInit;
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        ack_o      = 1'b0;
        resp_err_o = 1'b0;
        mem_cs_o   = 1'b0;
        mem_we_n_o = 1'b1;
        mem_oe_n_o = 1'b1;
        busy_o     = (state_q != StIdle);
        unique case (state_q)
            StSetup: begin
                mem_cs_o = 1'b1;
            end
            StAccess: begin
                mem_cs_o   = 1'b1;
                mem_we_n_o = ~we_q;
                mem_oe_n_o = we_q;
            end
            StHold: begin
                mem_cs_o = 1'b1;
            end
            StDone: begin
                ack_o      = 1'b1;
                resp_err_o = resp_q;
            end
            default: begin
                ack_o = 1'b0;
            end
        endcase
    end

    // Request capture; an illegal mode only records the error response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            mode_q  <= 3'b000;
            resp_q  <= 1'b0;
        end else if (accept) begin
            resp_q <= mode_i[2];
            if (!mode_i[2]) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                mode_q  <= mode_i;
            end
        end
    end

    // Read data capture on the edge that ends the last ACCESS cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 16'h0000;
        end else if (last_access && !we_q) begin
            rdata_q <= ecc_rdata_i;
        end
    end

    assign rdata_o     = rdata_q;
    assign mem_addr_o  = addr_q;
    assign ecc_wdata_o = wdata_q;
    assign ecc_sel_o   = mode_q;

`ifdef ECC_MEM_SEQ_ERRCNT_EN
    logic [2:0]           flag_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 err_inc;

    // Decoder flag captured alongside the read data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flag_q <= 3'b000;
        end else if (last_access && !we_q) begin
            flag_q <= ecc_flag_i;
        end
    end

    // Only legal ECC-mode reads (010/011) that saw a decoder flag count
    assign err_inc = (state_q == StDone) && !resp_q && !we_q &&
                     (mode_q[2:1] == 2'b01) && (flag_q != 3'b000);

    // Saturating error counter; clear has priority over increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else if (err_clr_i) begin
            err_q <= '0;
        end else if (err_inc && (err_q != {ERR_CNT_W{1'b1}})) begin
            err_q <= err_q + ERR_CNT_W'(1);
        end
    end

    assign err_count_o = err_q;
`else
    logic unused_errcnt;

    assign unused_errcnt = err_clr_i ^ (^ecc_flag_i);
    assign err_count_o   = '0;
`endif

endmodule

// File: tb/tb_ecc_mem_seq.sv
// tb_ecc_mem_seq: scenario tasks for ecc_mem_seq with a transaction-level reference model.
// Build with ECC_MEM_SEQ_ERRCNT_EN defined to exercise the error counter; otherwise the
// model expects err_count to stay at zero.
module tb_ecc_mem_seq;

    localparam int unsigned W  = 2;
    localparam int unsigned EW = 2;
`ifdef ECC_MEM_SEQ_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [15:0]   addr = 16'h0;
    logic [15:0]   wdata = 16'h0;
    logic [2:0]    mode = 3'b0;
    logic          ack, resp_err, busy, mem_cs, mem_we_n, mem_oe_n;
    logic [15:0]   rdata, ecc_wdata, mem_addr;
    logic [2:0]    ecc_sel;
    logic [15:0]   ecc_rdata = 16'h0;
    logic [2:0]    ecc_flag = 3'b0;
    logic          err_clr = 1'b0;
    logic [EW-1:0] err_count;

    ecc_mem_seq #(
        .WAIT_CYCLES(W),
        .ERR_CNT_W  (EW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .mode_i     (mode),
        .ack_o      (ack),
        .resp_err_o (resp_err),
        .rdata_o    (rdata),
        .busy_o     (busy),
        .ecc_sel_o  (ecc_sel),
        .ecc_wdata_o(ecc_wdata),
        .ecc_rdata_i(ecc_rdata),
        .ecc_flag_i (ecc_flag),
        .mem_addr_o (mem_addr),
        .mem_cs_o   (mem_cs),
        .mem_we_n_o (mem_we_n),
        .mem_oe_n_o (mem_oe_n),
        .err_clr_i  (err_clr),
        .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int fails   = 0;

    // Reference model state
    logic [15:0]   model_rdata = 16'h0;
    logic [EW-1:0] model_err   = '0;

    // Observations of the most recent transaction
    int            o_ack_k, o_we_cnt, o_oe_cnt, o_cs_cnt, o_first_strobe;
    int            o_outside, o_both, o_unstable, o_ack_cyc;
    logic          o_busy0, o_resp;
    logic [15:0]   o_rdata, o_addr, o_wd;
    logic [2:0]    o_sel;
    logic [EW-1:0] o_err0, o_err;

    // Drive one request, then watch the bus until ack (bounded) and update the model.
    task automatic run_txn(input logic t_we, input logic [15:0] t_addr, input logic [15:0] t_wd,
                           input logic [2:0] t_mode, input logic [15:0] t_rd,
                           input logic [2:0] t_flag, input bit hold, input bit clr);
        bit legal;
        int ack_exp;
        legal   = !t_mode[2];
        ack_exp = legal ? W + 3 : 1;
        o_ack_k = 0; o_we_cnt = 0; o_oe_cnt = 0; o_cs_cnt = 0; o_first_strobe = 0;
        o_outside = 0; o_both = 0; o_unstable = 0; o_ack_cyc = 0;
        o_addr = 16'hxxxx; o_wd = 16'hxxxx; o_sel = 3'bxxx; o_resp = 1'bx; o_rdata = 16'hxxxx;
        @(posedge clk); #1;
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wd; mode = t_mode; err_clr = 1'b0;
        ecc_rdata = 16'($urandom); ecc_flag = 3'($urandom);
        @(negedge clk);
        o_busy0 = busy;
        o_err0  = err_count;
        for (int k = 1; k <= W + 10; k++) begin
            @(posedge clk); #1;
            req       = hold ? 1'b1 : 1'($urandom);
            we        = 1'($urandom);
            addr      = 16'($urandom);
            wdata     = 16'($urandom);
            mode      = 3'($urandom);
            ecc_rdata = (k == W + 1) ? t_rd : 16'($urandom);
            ecc_flag  = (k == W + 1) ? t_flag : 3'($urandom);
            err_clr   = (k == ack_exp) ? clr : 1'b0;
            @(negedge clk);
            if (k == 1) begin
                o_addr = mem_addr; o_wd = ecc_wdata; o_sel = ecc_sel;
            end
            if (mem_cs) begin
                o_cs_cnt++;
                if (mem_addr !== t_addr || ecc_sel !== t_mode || (t_we && ecc_wdata !== t_wd))
                    o_unstable++;
            end
            if (!mem_we_n) o_we_cnt++;
            if (!mem_oe_n) o_oe_cnt++;
            if (!mem_we_n && !mem_oe_n) o_both++;
            if ((!mem_we_n || !mem_oe_n) && o_first_strobe == 0) o_first_strobe = k;
            if ((!mem_we_n || !mem_oe_n) && (k < 2 || k > W + 1)) o_outside++;
            if (ack) begin
                o_ack_k = k; o_ack_cyc = cyc; o_resp = resp_err; o_rdata = rdata;
                break;
            end
        end
        if (legal && !t_we) model_rdata = t_rd;
        if (clr) model_err = '0;
        else if (ERRCNT && legal && !t_we && (t_mode == 3'b010 || t_mode == 3'b011) &&
                 t_flag != 3'b000 && model_err != {EW{1'b1}})
            model_err = model_err + 1'b1;
    endtask

    // One quiet cycle; samples the settled counter and read data
    task automatic settle(input bit clr);
        @(posedge clk); #1;
        req = 1'b0; err_clr = clr;
        @(negedge clk);
        o_err = err_count; o_rdata = rdata; o_busy0 = busy;
        if (clr) model_err = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        vectors++;
        if ({ack, resp_err, busy, mem_cs, mem_we_n, mem_oe_n} !== 6'b000011) begin
            fails++;
            $display("FAIL reset_ctl got %b want 000011",
                     {ack, resp_err, busy, mem_cs, mem_we_n, mem_oe_n});
        end
        vectors++;
        if ({rdata, mem_addr, ecc_wdata, ecc_sel} !== 51'd0) begin
            fails++;
            $display("FAIL reset_data got %h/%h/%h/%b want all zero",
                     rdata, mem_addr, ecc_wdata, ecc_sel);
        end
        vectors++;
        if (err_count !== '0) begin
            fails++;
            $display("FAIL reset_err got %0d want 0", err_count);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_rdata = 16'h0; model_err = '0;
    endtask

    task automatic test_write;
        run_txn(1'b1, 16'h0012, 16'hA5A5, 3'b010, 16'h0, 3'b0, 1'b0, 1'b0);
        vectors++;
        if (o_ack_k != W + 3) begin
            fails++; $display("FAIL wr_latency got %0d want %0d", o_ack_k, W + 3);
        end
        vectors++;
        if (o_we_cnt != W || o_oe_cnt != 0 || o_first_strobe != 2) begin
            fails++;
            $display("FAIL wr_strobe got we=%0d oe=%0d first=%0d want we=%0d oe=0 first=2",
                     o_we_cnt, o_oe_cnt, o_first_strobe, W);
        end
        vectors++;
        if (o_cs_cnt != W + 2 || o_unstable != 0 || o_outside != 0) begin
            fails++;
            $display("FAIL wr_bus got cs=%0d unstable=%0d outside=%0d want cs=%0d 0 0",
                     o_cs_cnt, o_unstable, o_outside, W + 2);
        end
        vectors++;
        if (o_addr !== 16'h0012 || o_wd !== 16'hA5A5 || o_sel !== 3'b010 || o_resp !== 1'b0) begin
            fails++;
            $display("FAIL wr_setup got addr=%h wd=%h sel=%b resp=%b want 0012 A5A5 010 0",
                     o_addr, o_wd, o_sel, o_resp);
        end
    endtask

    task automatic test_read;
        run_txn(1'b0, 16'h0345, 16'h0, 3'b000, 16'h1234, 3'b001, 1'b0, 1'b0);
        vectors++;
        if (o_ack_k != W + 3 || o_oe_cnt != W || o_we_cnt != 0 || o_first_strobe != 2) begin
            fails++;
            $display("FAIL rd_timing got ack=%0d oe=%0d we=%0d first=%0d want %0d %0d 0 2",
                     o_ack_k, o_oe_cnt, o_we_cnt, o_first_strobe, W + 3, W);
        end
        vectors++;
        if (o_rdata !== 16'h1234 || o_resp !== 1'b0) begin
            fails++;
            $display("FAIL rd_data got %h resp=%b want 1234 resp=0", o_rdata, o_resp);
        end
    endtask

    task automatic test_illegal;
        run_txn(1'b1, 16'hBEEF, 16'h5555, 3'b101, 16'h0, 3'b0, 1'b0, 1'b0);
        vectors++;
        if (o_ack_k != 1 || o_resp !== 1'b1) begin
            fails++; $display("FAIL illegal_ack got k=%0d resp=%b want 1 1", o_ack_k, o_resp);
        end
        vectors++;
        if (o_cs_cnt != 0 || o_we_cnt != 0 || o_oe_cnt != 0) begin
            fails++;
            $display("FAIL illegal_bus got cs=%0d we=%0d oe=%0d want 0 0 0",
                     o_cs_cnt, o_we_cnt, o_oe_cnt);
        end
        vectors++;
        if (o_rdata !== model_rdata) begin
            fails++; $display("FAIL illegal_rdata got %h want %h", o_rdata, model_rdata);
        end
    endtask

    task automatic test_random;
        logic          t_we;
        logic [2:0]    t_mode;
        logic [EW-1:0] exp_err;
        for (int i = 0; i < 24; i++) begin
            t_we    = 1'($urandom);
            t_mode  = 3'($urandom);
            exp_err = model_err;
            run_txn(t_we, 16'($urandom), 16'($urandom), t_mode, 16'($urandom),
                    3'($urandom), 1'b0, 1'b0);
            vectors++;
            if (o_ack_k != (t_mode[2] ? 1 : W + 3) || o_resp !== t_mode[2] || o_busy0 !== 1'b0)
            begin
                fails++;
                $display("FAIL rnd_ack[%0d] got k=%0d resp=%b busy0=%b mode=%b", i, o_ack_k,
                         o_resp, o_busy0, t_mode);
            end
            vectors++;
            if (o_we_cnt != ((!t_mode[2] && t_we) ? W : 0) ||
                o_oe_cnt != ((!t_mode[2] && !t_we) ? W : 0) ||
                o_both != 0 || o_outside != 0 || o_unstable != 0) begin
                fails++;
                $display("FAIL rnd_strobe[%0d] got we=%0d oe=%0d both=%0d out=%0d unst=%0d",
                         i, o_we_cnt, o_oe_cnt, o_both, o_outside, o_unstable);
            end
            vectors++;
            if (o_rdata !== model_rdata || o_err0 !== exp_err) begin
                fails++;
                $display("FAIL rnd_data[%0d] got rdata=%h err=%0d want %h %0d", i, o_rdata,
                         o_err0, model_rdata, exp_err);
            end
        end
        settle(1'b0);
        vectors++;
        if (o_err !== model_err) begin
            fails++; $display("FAIL rnd_errcnt got %0d want %0d", o_err, model_err);
        end
    endtask

    task automatic test_back_to_back;
        int c[3];
        for (int i = 0; i < 3; i++) begin
            run_txn(1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom_range(3, 0)),
                    16'($urandom), 3'b000, 1'b1, 1'b0);
            c[i] = o_ack_cyc;
            vectors++;
            if (o_ack_k != W + 3 || o_unstable != 0) begin
                fails++;
                $display("FAIL b2b_txn[%0d] got k=%0d unstable=%0d want %0d 0", i, o_ack_k,
                         o_unstable, W + 3);
            end
        end
        vectors++;
        if (c[1] - c[0] != W + 4 || c[2] - c[1] != W + 4) begin
            fails++;
            $display("FAIL b2b_spacing got %0d,%0d want %0d", c[1] - c[0], c[2] - c[1], W + 4);
        end
        settle(1'b0);
    endtask

    task automatic test_reset_mid;
        int acks;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 16'h7777; wdata = 16'h1111; mode = 3'b011;
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_we_n !== 1'b1 || mem_cs !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid got we_n=%b cs=%b busy=%b want 1 0 0", mem_we_n, mem_cs, busy);
        end
        @(posedge clk); #1 rst = 1'b0;
        model_rdata = 16'h0; model_err = '0;
        acks = 0;
        for (int k = 0; k < W + 6; k++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        vectors++;
        if (acks != 0) begin
            fails++; $display("FAIL rst_noack got %0d acks want 0", acks);
        end
        run_txn(1'b0, 16'h0042, 16'h0, 3'b001, 16'hC3C3, 3'b0, 1'b0, 1'b0);
        vectors++;
        if (o_ack_k != W + 3 || o_rdata !== 16'hC3C3) begin
            fails++;
            $display("FAIL rst_recover got k=%0d rdata=%h want %0d C3C3", o_ack_k, o_rdata, W + 3);
        end
    endtask

    task automatic test_errcnt;
        settle(1'b1);
        for (int i = 0; i < 3; i++)
            run_txn(1'b0, 16'($urandom), 16'h0, 3'b011, 16'($urandom), 3'b001, 1'b0, 1'b0);
        run_txn(1'b0, 16'($urandom), 16'h0, 3'b000, 16'($urandom), 3'b001, 1'b0, 1'b0);
        settle(1'b0);
        vectors++;
        if (o_err !== model_err || o_err !== (ERRCNT ? EW'(3) : EW'(0))) begin
            fails++; $display("FAIL err_count3 got %0d want %0d", o_err, model_err);
        end
        run_txn(1'b0, 16'($urandom), 16'h0, 3'b010, 16'($urandom), 3'b010, 1'b0, 1'b1);
        settle(1'b0);
        vectors++;
        if (o_err !== model_err || o_err !== EW'(0)) begin
            fails++; $display("FAIL err_clr_wins got %0d want 0", o_err);
        end
        for (int i = 0; i < 5; i++)
            run_txn(1'b0, 16'($urandom), 16'h0, 3'b010, 16'($urandom), 3'($urandom_range(7, 1)),
                    1'b0, 1'b0);
        settle(1'b0);
        vectors++;
        if (o_err !== model_err) begin
            fails++; $display("FAIL err_saturate got %0d want %0d", o_err, model_err);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_illegal();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_errcnt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
